// File: rtl/sp_usb_fifo.sv
// FT245-style USB FIFO bridge: TX/RX byte FIFOs with fair read/write arbitration and counter-timed strobes.
// Define SP_USB_FIFO_STATS_EN to add the tx_bytes/rx_bytes transfer counters.
module sp_usb_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int SETUP_CYC   = 1,
  parameter int WR_CYC      = 3,
  parameter int RD_CYC      = 3,
  parameter int RECOVER_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  tri   [7:0]            usb_data,
  input  logic                  rxf_n,
  input  logic                  txe_n,
  output logic                  rd_n,
  output logic                  wr_n,
  input  logic [7:0]            din,
  input  logic                  write,
  output logic                  full,
  output logic [7:0]            dout,
  input  logic                  read,
  output logic                  avail,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic [DEPTH_LOG2:0]   rx_level
`ifdef SP_USB_FIFO_STATS_EN
  ,
  output logic [31:0]           tx_bytes,
  output logic [31:0]           rx_bytes
`endif
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [3:0]        SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0]        WR_LD    = 4'(WR_CYC - 1);
  localparam logic [3:0]        RD_LD    = 4'(RD_CYC - 1);
  localparam logic [3:0]        REC_LD   = 4'(RECOVER_CYC - 1);
  localparam logic              DIR_READ  = 1'b0;
  localparam logic              DIR_WRITE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SETUP, S_WR_PULSE, S_RD_PULSE, S_RECOVER
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_dir_q, last_dir_d;
  logic       rd_n_q, wr_n_q, oe_q, oe_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_pop, rx_push;

  // rxf_n/txe_n are asynchronous: two-flop synchronisers on the inverted strobes
  logic [1:0] rxf_sync_q, txe_sync_q;
  logic       rxf, txe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxf_sync_q <= '0;
      txe_sync_q <= '0;
    end else begin
      rxf_sync_q <= {rxf_sync_q[0], ~rxf_n};
      txe_sync_q <= {txe_sync_q[0], ~txe_n};
    end
  end

  assign rxf = &rxf_sync_q;
  assign txe = &txe_sync_q;

  // TX FIFO
  logic [7:0]            tx_mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_rptr_q;
  logic [DEPTH_LOG2:0]   tx_level_q;
  logic                  tx_push;

  assign full    = (tx_level_q == FULL_LVL);
  assign tx_push = write & ~full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
    end else begin
      tx_wptr_q  <= tx_wptr_q + DEPTH_LOG2'(tx_push);
      tx_rptr_q  <= tx_rptr_q + DEPTH_LOG2'(tx_pop);
      tx_level_q <= tx_level_q + (DEPTH_LOG2+1)'(tx_push) - (DEPTH_LOG2+1)'(tx_pop);
    end
  end

  // RX FIFO with registered first-word fall-through head
  logic [7:0]            rx_mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_rptr_q, rx_rptr_d;
  logic [DEPTH_LOG2:0]   rx_level_q, rx_level_d;
  logic [7:0]            dout_q, dout_d;
  logic                  rx_pop, rx_wr;

  assign avail  = (rx_level_q != '0);
  assign rx_pop = read & avail;
  assign rx_wr  = rx_push & (rx_level_q != FULL_LVL);

  always_comb begin
    rx_rptr_d  = rx_rptr_q + DEPTH_LOG2'(rx_pop);
    rx_level_d = rx_level_q + (DEPTH_LOG2+1)'(rx_wr) - (DEPTH_LOG2+1)'(rx_pop);
    dout_d     = dout_q;
    // New head is the byte being pushed only when everything older has drained
    if (rx_level_d != '0)
      dout_d = (rx_wr && rx_rptr_d == rx_wptr_q) ? usb_data : rx_mem_q[rx_rptr_d];
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem_q[rx_wptr_q] <= usb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_level_q <= '0;
      dout_q     <= '0;
    end else begin
      rx_wptr_q  <= rx_wptr_q + DEPTH_LOG2'(rx_wr);
      rx_rptr_q  <= rx_rptr_d;
      rx_level_q <= rx_level_d;
      dout_q     <= dout_d;
    end
  end

  // Transfer FSM
  logic tx_ok, rx_ok;
  assign tx_ok = (tx_level_q != '0) & txe;
  assign rx_ok = (rx_level_q != FULL_LVL) & rxf;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dir_d = last_dir_q;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_ok && (!rx_ok || last_dir_q == DIR_READ)) begin
          state_d    = S_WR_SETUP;
          cnt_d      = SETUP_LD;
          last_dir_d = DIR_WRITE;
        end else if (rx_ok) begin
          state_d    = S_RD_PULSE;
          cnt_d      = RD_LD;
          last_dir_d = DIR_READ;
        end
      end
      S_WR_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_WR_PULSE;
          cnt_d   = WR_LD;
        end else cnt_d = cnt_q - 4'd1;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          tx_pop  = 1'b1;
          state_d = S_RECOVER;
          cnt_d   = REC_LD;
        end else cnt_d = cnt_q - 4'd1;
      end
      S_RD_PULSE: begin
        if (cnt_q == '0) begin
          rx_push = 1'b1;
          state_d = S_RECOVER;
          cnt_d   = REC_LD;
        end else cnt_d = cnt_q - 4'd1;
      end
      S_RECOVER: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus is driven through the write states plus one hold cycle into RECOVER
  always_comb begin
    oe_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
           (state_d == S_RECOVER && state_q == S_WR_PULSE);
    tx_data_d = (state_q == S_IDLE && state_d == S_WR_SETUP) ? tx_mem_q[tx_rptr_q] : tx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_dir_q <= DIR_READ;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dir_q <= last_dir_d;
      rd_n_q     <= (state_d != S_RD_PULSE);
      wr_n_q     <= (state_d != S_WR_PULSE);
      oe_q       <= oe_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign usb_data = oe_q ? tx_data_q : 8'hzz;
  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;
  assign dout     = dout_q;
  assign tx_level = tx_level_q;
  assign rx_level = rx_level_q;

`ifdef SP_USB_FIFO_STATS_EN
  logic [31:0] tx_bytes_q, rx_bytes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_bytes_q <= '0;
      rx_bytes_q <= '0;
    end else begin
      tx_bytes_q <= tx_bytes_q + 32'(tx_pop);
      rx_bytes_q <= rx_bytes_q + 32'(rx_wr);
    end
  end

  assign tx_bytes = tx_bytes_q;
  assign rx_bytes = rx_bytes_q;
`endif

endmodule
